hilo_pipe: RTL and testbench

Downstream companion of the EX-stage multiply/divide unit. Carries HI/LO writes (MULT/DIV results, MTHI/MTLO) from EX through MEM and WB pipeline registers and commits them to an architectural HI/LO copy at WB. Drives the write-back strobes for the HI/LO write port. Also resolves MFHI/MFLO reads in EX, either by forwarding the newest in-flight value or by requesting a stall.

---
 rtl/hilo_pipe.sv | 144 ++++++++++++++
 tb/tb_hilo_pipe.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_pipe.sv
// hilo_pipe: carries HI/LO writes from EX through the EX/MEM (M) and MEM/WB (W)
// registers, commits them to the architectural HI/LO copy at WB and resolves
// MFHI/MFLO reads in EX.
//
// Build option: macro HILO_FWD_EN
//   defined   - EX reads are forwarded from M, then W, then committed HI/LO;
//               hilo_stall is tied low.
//   undefined - EX reads see committed HI/LO only; hilo_stall is raised while
//               a matching write is still in M or W.
//
// Reset is synchronous and active-low on rst.

module hilo_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_hi_we,
    input  logic [31:0] ex_hi_data,
    input  logic        ex_lo_we,
    input  logic [31:0] ex_lo_data,
    input  logic        ex_rd_hi,
    input  logic        ex_rd_lo,
    input  logic        ex_stall,
    input  logic        ex_flush,
    input  logic        mem_stall,
    input  logic        mem_flush,
    output logic [31:0] rd_hi_data,
    output logic [31:0] rd_lo_data,
    output logic        hilo_stall,
    output logic        wb_hi_write,
    output logic [31:0] wb_hi_write_data,
    output logic        wb_lo_write,
    output logic [31:0] wb_lo_write_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // EX/MEM stage register
    logic        r_m_hi_we;
    logic [31:0] r_m_hi_data;
    logic        r_m_lo_we;
    logic [31:0] r_m_lo_data;

    // MEM/WB stage register
    logic        r_w_hi_we;
    logic [31:0] r_w_hi_data;
    logic        r_w_lo_we;
    logic [31:0] r_w_lo_data;

    // Architectural HI/LO
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [31:0] w_rd_hi;
    logic [31:0] w_rd_lo;
    logic        w_stall;

    // M: flush beats stall; only the write enables matter for a bubble, so the
    // data fields are left untouched on reset/flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_m_hi_we <= 1'b0;
            r_m_lo_we <= 1'b0;
        end else if (ex_flush) begin
            r_m_hi_we <= 1'b0;
            r_m_lo_we <= 1'b0;
        end else if (!ex_stall) begin
            r_m_hi_we   <= ex_hi_we;
            r_m_hi_data <= ex_hi_data;
            r_m_lo_we   <= ex_lo_we;
            r_m_lo_data <= ex_lo_data;
        end
    end

    // W: reset clears everything so the write-back port idles at zero; a
    // flush or a MEM stall inserts a bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_w_hi_we   <= 1'b0;
            r_w_hi_data <= 32'd0;
            r_w_lo_we   <= 1'b0;
            r_w_lo_data <= 32'd0;
        end else if (mem_flush || mem_stall) begin
            r_w_hi_we <= 1'b0;
            r_w_lo_we <= 1'b0;
        end else begin
            r_w_hi_we   <= r_m_hi_we;
            r_w_hi_data <= r_m_hi_data;
            r_w_lo_we   <= r_m_lo_we;
            r_w_lo_data <= r_m_lo_data;
        end
    end

    // Commit from W; upstream stall/flush controls have no say here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            if (r_w_hi_we) begin
                r_hi <= r_w_hi_data;
            end
            if (r_w_lo_we) begin
                r_lo <= r_w_lo_data;
            end
        end
    end

    // EX read resolution: newest in-flight value wins, or stall until it lands.
    always_comb begin
        w_rd_hi = r_hi;
        w_rd_lo = r_lo;
        w_stall = 1'b0;
`ifdef HILO_FWD_EN
        if (r_m_hi_we) begin
            w_rd_hi = r_m_hi_data;
        end else if (r_w_hi_we) begin
            w_rd_hi = r_w_hi_data;
        end
        if (r_m_lo_we) begin
            w_rd_lo = r_m_lo_data;
        end else if (r_w_lo_we) begin
            w_rd_lo = r_w_lo_data;
        end
`else
        w_stall = (ex_rd_hi && (r_m_hi_we || r_w_hi_we)) ||
                  (ex_rd_lo && (r_m_lo_we || r_w_lo_we));
`endif
    end

    // Reader outputs are forced quiet while reset is being applied, before the
    // reset edge has cleared the registers.
    assign rd_hi_data = rst ? w_rd_hi : 32'd0;
    assign rd_lo_data = rst ? w_rd_lo : 32'd0;
    assign hilo_stall = rst & w_stall;

    assign wb_hi_write      = r_w_hi_we;
    assign wb_hi_write_data = r_w_hi_data;
    assign wb_lo_write      = r_w_lo_we;
    assign wb_lo_write_data = r_w_lo_data;

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: tb/tb_hilo_pipe.sv
// Testbench for hilo_pipe: a transaction-level model of the two pipeline
// slots and the committed HI/LO is checked against the DUT on every cycle,
// and directed sequences pin the model with hand-computed literals.
// Follows HILO_FWD_EN the same way the design does.

module tb_hilo_pipe;

    logic        clk;
    logic        rst;
    logic        ex_hi_we;
    logic [31:0] ex_hi_data;
    logic        ex_lo_we;
    logic [31:0] ex_lo_data;
    logic        ex_rd_hi;
    logic        ex_rd_lo;
    logic        ex_stall;
    logic        ex_flush;
    logic        mem_stall;
    logic        mem_flush;
    logic [31:0] rd_hi_data;
    logic [31:0] rd_lo_data;
    logic        hilo_stall;
    logic        wb_hi_write;
    logic [31:0] wb_hi_write_data;
    logic        wb_lo_write;
    logic [31:0] wb_lo_write_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    hilo_pipe dut (
        .clk              (clk),
        .rst              (rst),
        .ex_hi_we         (ex_hi_we),
        .ex_hi_data       (ex_hi_data),
        .ex_lo_we         (ex_lo_we),
        .ex_lo_data       (ex_lo_data),
        .ex_rd_hi         (ex_rd_hi),
        .ex_rd_lo         (ex_rd_lo),
        .ex_stall         (ex_stall),
        .ex_flush         (ex_flush),
        .mem_stall        (mem_stall),
        .mem_flush        (mem_flush),
        .rd_hi_data       (rd_hi_data),
        .rd_lo_data       (rd_lo_data),
        .hilo_stall       (hilo_stall),
        .wb_hi_write      (wb_hi_write),
        .wb_hi_write_data (wb_hi_write_data),
        .wb_lo_write      (wb_lo_write),
        .wb_lo_write_data (wb_lo_write_data),
        .hi               (hi),
        .lo               (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct packed {
        bit        hwe;
        bit [31:0] hd;
        bit        lwe;
        bit [31:0] ld;
    } ent_t;

    ent_t      mm, ww, nm, nw;   // in-flight write past EX, past MEM
    bit [31:0] chi, clo;         // architectural HI/LO

    always @(posedge clk) begin
        if (!rst) begin
            mm.hwe = 1'b0;
            mm.lwe = 1'b0;
            ww     = '0;
            chi    = 32'd0;
            clo    = 32'd0;
        end else begin
            if (ww.hwe) chi = ww.hd;
            if (ww.lwe) clo = ww.ld;
            nw = mm;
            if (mem_flush || mem_stall) begin
                nw.hwe = 1'b0;
                nw.lwe = 1'b0;
            end
            nm = mm;
            if (ex_flush) begin
                nm.hwe = 1'b0;
                nm.lwe = 1'b0;
            end else if (!ex_stall) begin
                nm = '{hwe: ex_hi_we, hd: ex_hi_data, lwe: ex_lo_we, ld: ex_lo_data};
            end
            mm = nm;
            ww = nw;
        end
    end

    function automatic logic [31:0] exp_rd(input bit rd_lo_side);
        logic [31:0] v;
        if (!rst) return 32'd0;
        v = rd_lo_side ? clo : chi;
`ifdef HILO_FWD_EN
        if (!rd_lo_side) begin
            if (mm.hwe) v = mm.hd;
            else if (ww.hwe) v = ww.hd;
        end else begin
            if (mm.lwe) v = mm.ld;
            else if (ww.lwe) v = ww.ld;
        end
`endif
        return v;
    endfunction

    function automatic logic exp_stall();
`ifdef HILO_FWD_EN
        return 1'b0;
`else
        if (!rst) return 1'b0;
        return (ex_rd_hi && (mm.hwe || ww.hwe)) || (ex_rd_lo && (mm.lwe || ww.lwe));
`endif
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("hi", hi, chi);
            chk("lo", lo, clo);
            chk("wb_hi_write", {31'd0, wb_hi_write}, {31'd0, ww.hwe});
            chk("wb_lo_write", {31'd0, wb_lo_write}, {31'd0, ww.lwe});
            if (ww.hwe) chk("wb_hi_write_data", wb_hi_write_data, ww.hd);
            if (ww.lwe) chk("wb_lo_write_data", wb_lo_write_data, ww.ld);
            chk("rd_hi_data", rd_hi_data, exp_rd(1'b0));
            chk("rd_lo_data", rd_lo_data, exp_rd(1'b1));
            chk("hilo_stall", {31'd0, hilo_stall}, {31'd0, exp_stall()});
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        rst        = 1'b1;
        ex_hi_we   = 1'b0;
        ex_hi_data = 32'd0;
        ex_lo_we   = 1'b0;
        ex_lo_data = 32'd0;
        ex_rd_hi   = 1'b0;
        ex_rd_lo   = 1'b0;
        ex_stall   = 1'b0;
        ex_flush   = 1'b0;
        mem_stall  = 1'b0;
        mem_flush  = 1'b0;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr_hi(input logic [31:0] d);
        ex_hi_we   = 1'b1;
        ex_hi_data = d;
    endtask

    task automatic wr_lo(input logic [31:0] d);
        ex_lo_we   = 1'b1;
        ex_lo_data = d;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        fin();
        chk_en = 1'b1;
        rst = 1'b0;
        mid(); fin();

        // Reset released
        mid();
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset wb_hi_write", {31'd0, wb_hi_write}, 32'd0);
        chk("reset wb_lo_write", {31'd0, wb_lo_write}, 32'd0);
        chk("reset wb_hi_write_data", wb_hi_write_data, 32'd0);
        chk("reset wb_lo_write_data", wb_lo_write_data, 32'd0);
        chk("reset rd_hi_data", rd_hi_data, 32'd0);
        chk("reset hilo_stall", {31'd0, hilo_stall}, 32'd0);
        fin();

        // Simple HI write
        wr_hi(32'h1234_5678); mid(); fin();
        mid(); fin();
        mid();
        chk("simple wb_hi_write c2", {31'd0, wb_hi_write}, 32'd1);
        chk("simple wb_hi_data c2", wb_hi_write_data, 32'h1234_5678);
        chk("simple wb_lo_write c2", {31'd0, wb_lo_write}, 32'd0);
        fin();
        mid();
        chk("simple hi c3", hi, 32'h1234_5678);
        chk("simple lo c3", lo, 32'd0);
        fin();

        // LO back-to-back with reads
        wr_lo(32'hA); mid(); fin();
        wr_lo(32'hB); ex_rd_lo = 1'b1; mid();
`ifdef HILO_FWD_EN
        chk("fwd rd_lo c1", rd_lo_data, 32'hA);
`else
        chk("stall lo c1", {31'd0, hilo_stall}, 32'd1);
        chk("stall rd_lo c1", rd_lo_data, 32'd0);
`endif
        fin();
        ex_rd_lo = 1'b1; mid();
`ifdef HILO_FWD_EN
        chk("fwd rd_lo c2", rd_lo_data, 32'hB);
        chk("fwd stall c2", {31'd0, hilo_stall}, 32'd0);
`else
        chk("stall lo c2", {31'd0, hilo_stall}, 32'd1);
`endif
        fin();
        mid(); fin();
        mid();
        chk("lo after b2b", lo, 32'hB);
        fin();

        // HI read hazard
        wr_hi(32'h55); mid(); fin();
        ex_rd_hi = 1'b1; mid();
`ifdef HILO_FWD_EN
        chk("fwd hi c1 stall", {31'd0, hilo_stall}, 32'd0);
        chk("fwd rd_hi c1", rd_hi_data, 32'h55);
`else
        chk("stall hi c1", {31'd0, hilo_stall}, 32'd1);
`endif
        fin();
        ex_rd_hi = 1'b1; mid();
`ifndef HILO_FWD_EN
        chk("stall hi c2", {31'd0, hilo_stall}, 32'd1);
`endif
        fin();
        ex_rd_hi = 1'b1; mid();
        chk("stall hi c3", {31'd0, hilo_stall}, 32'd0);
        chk("rd_hi c3", rd_hi_data, 32'h55);
        fin();

        // EX flush kills the write
        wr_hi(32'h99); ex_flush = 1'b1; mid(); fin();
        mid(); chk("exflush wb c1", {31'd0, wb_hi_write}, 32'd0); fin();
        mid(); chk("exflush wb c2", {31'd0, wb_hi_write}, 32'd0); fin();
        mid(); chk("exflush hi c3", hi, 32'h55); fin();

        // MEM flush kills the write one cycle later
        wr_hi(32'h99); mid(); fin();
        mem_flush = 1'b1; mid(); fin();
        mid(); chk("memflush wb c2", {31'd0, wb_hi_write}, 32'd0); fin();
        mid(); chk("memflush hi c3", hi, 32'h55); fin();

        // MEM stall: M holds, W bubbles, write lands one cycle late
        wr_hi(32'h77); mid(); fin();
        mem_stall = 1'b1; ex_stall = 1'b1; wr_hi(32'hDEAD); mid(); fin();
        mid(); chk("memstall wb c2", {31'd0, wb_hi_write}, 32'd0); fin();
        mid();
        chk("memstall wb c3", {31'd0, wb_hi_write}, 32'd1);
        chk("memstall wb data c3", wb_hi_write_data, 32'h77);
        fin();
        mid(); chk("memstall hi c4", hi, 32'h77); fin();
        mid(); chk("memstall hi c5", hi, 32'h77); fin();

        // ex_stall and ex_flush together: flush wins, no duplicate commit
        wr_hi(32'h33); mid(); fin();
        ex_stall = 1'b1; ex_flush = 1'b1; mid(); fin();
        mid();
        chk("stall+flush wb c2", {31'd0, wb_hi_write}, 32'd1);
        chk("stall+flush data c2", wb_hi_write_data, 32'h33);
        fin();
        mid(); chk("stall+flush wb c3", {31'd0, wb_hi_write}, 32'd0); fin();

        // HI+LO together, then back-to-back HI
        wr_hi(32'h111); wr_lo(32'h222); mid(); fin();
        wr_hi(32'h333); mid(); fin();
        ex_rd_hi = 1'b1; mid();
`ifdef HILO_FWD_EN
        chk("b2b rd_hi c2", rd_hi_data, 32'h333);
`else
        chk("b2b stall c2", {31'd0, hilo_stall}, 32'd1);
`endif
        chk("b2b wb_hi data c2", wb_hi_write_data, 32'h111);
        chk("b2b wb_lo data c2", wb_lo_write_data, 32'h222);
        fin();
        mid(); fin();
        mid();
        chk("b2b hi c4", hi, 32'h333);
        chk("b2b lo c4", lo, 32'h222);
        fin();

        // Reset with writes in M and W
        wr_hi(32'hAAAA); wr_lo(32'hBBBB); mid(); fin();
        wr_hi(32'hCCCC); mid(); fin();
        rst = 1'b0; ex_rd_hi = 1'b1; mid();
        chk("rst rd_hi_data", rd_hi_data, 32'd0);
        chk("rst hilo_stall", {31'd0, hilo_stall}, 32'd0);
        fin();
        mid();
        chk("rst wb_hi_write", {31'd0, wb_hi_write}, 32'd0);
        chk("rst wb_lo_write", {31'd0, wb_lo_write}, 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        fin();
        mid(); fin();
        mid();
        chk("post-rst hi", hi, 32'd0);
        chk("post-rst lo", lo, 32'd0);
        fin();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
